inst_dec: RTL and testbench
===========================

Name: inst_dec

Overview:
- Instruction decode stage. Sits directly downstream of the fetch stage and consumes its instruction word and registered PC+4 (pc4_dc).
- Contains the IF/ID pipeline register, a 32x32 register file with a write-back port, load-use hazard detection and the ID/EX output register.
- Returns the hazard stall to fetch and supplies decoded operands and fields to execute.

Parameters:
- DATA_W, 32, datapath and register width.
- NUM_REGS, 32, register file depth; register 0 hardwired to zero.
- NOP_WORD, 32'h0000_0000, instruction word injected as a bubble.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- instruction  input  32  instruction word from fetch
- pc4_dc  input  32  PC+4 from fetch, aligned with instruction
- flush  input  1  squash IF/ID contents (taken branch/jump)
- wb_en  input  1  register file write enable
- wb_addr  input  5  write-back register index
- wb_data  input  32  write-back data
- ex_mem_read  input  1  instruction currently in EX is a load
- ex_rt  input  5  destination register of the instruction in EX
- hazard  output  1  stall request to fetch (combinational)
- opcode_ex  output  6  registered instr[31:26]
- funct_ex  output  6  registered instr[5:0]
- rs_ex, rt_ex, rd_ex  output  5 each  registered register indices
- rs_data_ex, rt_data_ex  output  32 each  registered register file read data
- imm_ex  output  32  registered extended immediate
- br_target_ex  output  32  registered pc4 + (sext(imm) << 2)
- pc4_ex  output  32  registered PC+4
- valid_ex  output  1  ID/EX slot holds a real instruction

Behaviour:
- Reset: IF/ID instr = NOP_WORD, IF/ID pc4 = 0, IF/ID valid = 0. All ID/EX outputs = 0, valid_ex = 0. All registers cleared to 0. hazard = 0 while rst is high.
- IF/ID register, evaluated each posedge with priority flush > hazard > load:
  - flush: instr = NOP_WORD, valid = 0.
  - hazard: hold instr, pc4 and valid.
  - otherwise: capture instruction and pc4_dc, valid = 1.
- Decode fields from IF/ID instr: rs = [25:21], rt = [20:16], rd = [15:11], imm16 = [15:0].
- Immediate extension:
  - Zero-extend for opcodes 001100 (andi), 001101 (ori), 001110 (xori).
  - Sign-extend for all other opcodes.
- br_target = IF/ID pc4 + (sext(imm16) << 2), modulo 2^32. Wrap-around is silent.
- Register file:
  - Write at posedge when wb_en=1 and wb_addr != 0. Writes to r0 are ignored.
  - Reads of index 0 always return 0.
  - Same-cycle read/write behaviour is set by WB_BYPASS_EN (see Optional Feature).
- Hazard: hazard = IF/ID valid and ex_mem_read and (ex_rt != 0) and (ex_rt == rs or ex_rt == rt). It is purely combinational and drives the fetch stall.
- ID/EX register, evaluated each posedge with priority flush > hazard > load:
  - flush or hazard: insert bubble. All outputs 0, valid_ex = 0.
  - otherwise: load the decoded values, valid_ex = IF/ID valid.
- Latency: instruction presented before edge N is captured at N. Its decoded outputs appear after edge N+1. This gives 2 cycles from fetch output to execute input.
- Load-use stall lasts exactly one cycle per hazard. The next cycle ex_mem_read reflects the bubble (0) and the held instruction proceeds.
- Simultaneous flush and hazard: flush wins in both registers, and no stall is held.
- Reset mid-operation: all state is cleared on the first edge with rst=1. Any pending stall is dropped.
- Write-back is independent of stall and flush; writes always commit when wb_en=1.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: if wb_en=1 and wb_addr != 0 and wb_addr matches rs (or rt) in the same cycle, the read returns wb_data. This write-through bypass gives half-cycle write-before-read semantics.
- Undefined: reads return the pre-write register contents. The new value is visible from the following cycle.
- Register 0 returns 0 in both cases.

Test Plan:
- Reset → ID/EX outputs: apply rst for 2 cycles, then release with instruction=32'h2008_0005 (addi r8,r0,5) and pc4_dc=4. Require valid_ex=0 and all outputs 0 during reset. Two edges after release: opcode_ex=6'b001000, rt_ex=8, imm_ex=5, pc4_ex=4, valid_ex=1.
- Immediate extension: instruction ori with imm 16'hFFFF → imm_ex=32'h0000_FFFF. addi with imm 16'hFFFF → imm_ex=32'hFFFF_FFFF. With pc4=32'h100 and imm 16'hFFFF, br_target_ex=32'h0FC.
- Register file: write r5=32'hDEAD_BEEF (wb_en=1) while decoding an instruction with rs=5. WB_BYPASS_EN defined → rs_data_ex=32'hDEAD_BEEF. Undefined → old value 0. A write to r0 leaves reads of r0 = 0.
- Load-use stall: set ex_mem_read=1, ex_rt=9 with IF/ID rs=9. Require hazard=1, IF/ID held, next valid_ex=0. Drop ex_mem_read the next cycle → the instruction issues with valid_ex=1 one cycle late. ex_rt=0 gives no stall.
- Flush: assert flush for one cycle with a valid instruction in IF/ID. Require both stages to become bubbles (valid_ex=0 for 2 consecutive cycles). flush together with hazard=1 → hazard deasserts next cycle and no hold occurs.
- Wrap: pc4_dc=32'hFFFF_FFFC with imm 16'h0001 → br_target_ex=32'h0000_0000.

Source files
------------

// File: rtl/inst_dec.sv
// Instruction decode stage: IF/ID register, 32-entry register file, load-use
// hazard detection and ID/EX register. Optional write-through bypass: WB_BYPASS_EN.
module inst_dec #(
  parameter int          DATA_W   = 32,
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic [31:0]       pc4_dc,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  output logic              hazard,
  output logic [5:0]        opcode_ex,
  output logic [5:0]        funct_ex,
  output logic [4:0]        rs_ex,
  output logic [4:0]        rt_ex,
  output logic [4:0]        rd_ex,
  output logic [DATA_W-1:0] rs_data_ex,
  output logic [DATA_W-1:0] rt_data_ex,
  output logic [31:0]       imm_ex,
  output logic [31:0]       br_target_ex,
  output logic [31:0]       pc4_ex,
  output logic              valid_ex
);

  // IF/ID pipeline register
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        ifid_vld_q, ifid_vld_d;

  always_comb begin
    instr_d    = instruction;
    pc4_d      = pc4_dc;
    ifid_vld_d = 1'b1;
    if (flush) begin
      instr_d    = NOP_WORD;
      pc4_d      = pc4_q;
      ifid_vld_d = 1'b0;
    end else if (hazard) begin
      instr_d    = instr_q;
      pc4_d      = pc4_q;
      ifid_vld_d = ifid_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_WORD;
      pc4_q      <= '0;
      ifid_vld_q <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      ifid_vld_q <= ifid_vld_d;
    end
  end

  // Field decode
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] sext_imm, ext_imm, br_target;

  assign opcode    = instr_q[31:26];
  assign rs        = instr_q[25:21];
  assign rt        = instr_q[20:16];
  assign rd        = instr_q[15:11];
  assign funct     = instr_q[5:0];
  assign imm16     = instr_q[15:0];
  assign sext_imm  = {{16{imm16[15]}}, imm16};
  // andi/ori/xori take a zero-extended immediate; everything else sign-extends
  assign ext_imm   = (opcode == 6'b001100 || opcode == 6'b001101 || opcode == 6'b001110)
                     ? {16'h0000, imm16} : sext_imm;
  assign br_target = pc4_q + {sext_imm[29:0], 2'b00};

  // Register file
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rs_rd, rt_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_rd = (rs == 5'd0) ? '0 : rf_q[rs];
    rt_rd = (rt == 5'd0) ? '0 : rf_q[rt];
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr != 5'd0 && wb_addr == rs) rs_rd = wb_data;
    if (wb_en && wb_addr != 5'd0 && wb_addr == rt) rt_rd = wb_data;
`endif
  end

  // Load-use: the load in EX produces ex_rt too late for this instruction
  assign hazard = !rst && ifid_vld_q && ex_mem_read && (ex_rt != 5'd0) &&
                  (ex_rt == rs || ex_rt == rt);

  // ID/EX pipeline register
  logic [5:0]        opcode_q, funct_q;
  logic [4:0]        rs_q, rt_q, rd_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q;
  logic [31:0]       imm_q, br_q, pc4ex_q;
  logic              vld_q;

  always_ff @(posedge clk) begin
    if (rst || flush || hazard) begin
      opcode_q  <= '0;
      funct_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      br_q      <= '0;
      pc4ex_q   <= '0;
      vld_q     <= 1'b0;
    end else begin
      opcode_q  <= opcode;
      funct_q   <= funct;
      rs_q      <= rs;
      rt_q      <= rt;
      rd_q      <= rd;
      rs_data_q <= rs_rd;
      rt_data_q <= rt_rd;
      imm_q     <= ext_imm;
      br_q      <= br_target;
      pc4ex_q   <= pc4_q;
      vld_q     <= ifid_vld_q;
    end
  end

  assign opcode_ex    = opcode_q;
  assign funct_ex     = funct_q;
  assign rs_ex        = rs_q;
  assign rt_ex        = rt_q;
  assign rd_ex        = rd_q;
  assign rs_data_ex   = rs_data_q;
  assign rt_data_ex   = rt_data_q;
  assign imm_ex       = imm_q;
  assign br_target_ex = br_q;
  assign pc4_ex       = pc4ex_q;
  assign valid_ex     = vld_q;

endmodule

// File: tb/tb_inst_dec.sv
// Directed bench for inst_dec: reset, decode latency, immediates, register
// file, load-use stall, flush, branch-target wrap and mid-run reset.
module tb_inst_dec;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, pc4_dc;
  logic        flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        hazard;
  logic [5:0]  opcode_ex, funct_ex;
  logic [4:0]  rs_ex, rt_ex, rd_ex;
  logic [31:0] rs_data_ex, rt_data_ex, imm_ex, br_target_ex, pc4_ex;
  logic        valid_ex;

  int checks = 0;
  int errors = 0;

  inst_dec dut (
    .clk(clk), .rst(rst), .instruction(instruction), .pc4_dc(pc4_dc),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .hazard(hazard),
    .opcode_ex(opcode_ex), .funct_ex(funct_ex), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .rd_ex(rd_ex), .rs_data_ex(rs_data_ex), .rt_data_ex(rt_data_ex),
    .imm_ex(imm_ex), .br_target_ex(br_target_ex), .pc4_ex(pc4_ex),
    .valid_ex(valid_ex)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; instruction = 32'h0; pc4_dc = 32'h0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; ex_mem_read = 1'b0; ex_rt = 5'd0;

    // Reset
    tick; tick;
    chk("rst_valid", {31'b0, valid_ex}, 32'd0);
    chk("rst_opcode", {26'b0, opcode_ex}, 32'd0);
    chk("rst_imm", imm_ex, 32'd0);
    chk("rst_pc4", pc4_ex, 32'd0);
    chk("rst_rsdata", rs_data_ex, 32'd0);
    ex_mem_read = 1'b1; ex_rt = 5'd8; #1;
    chk("rst_hazard", {31'b0, hazard}, 32'd0);
    ex_mem_read = 1'b0; ex_rt = 5'd0;

    // addi r8,r0,5: two edges to reach ID/EX
    rst = 1'b0; instruction = 32'h2008_0005; pc4_dc = 32'd4;
    tick;
    chk("lat_valid_n", {31'b0, valid_ex}, 32'd0);
    tick;
    chk("addi_opcode", {26'b0, opcode_ex}, 32'h08);
    chk("addi_rt", {27'b0, rt_ex}, 32'd8);
    chk("addi_rs", {27'b0, rs_ex}, 32'd0);
    chk("addi_imm", imm_ex, 32'd5);
    chk("addi_pc4", pc4_ex, 32'd4);
    chk("addi_br", br_target_ex, 32'd24);
    chk("addi_valid", {31'b0, valid_ex}, 32'd1);

    // Immediate extension
    instruction = 32'h3401_FFFF; pc4_dc = 32'h100;
    tick; tick;
    chk("ori_imm", imm_ex, 32'h0000_FFFF);
    chk("ori_br", br_target_ex, 32'h0000_00FC);
    instruction = 32'h2001_FFFF;
    tick; tick;
    chk("addi_neg_imm", imm_ex, 32'hFFFF_FFFF);
    chk("addi_neg_br", br_target_ex, 32'h0000_00FC);

    // Register file: write r5 while decoding rs=5
    instruction = 32'h00A6_3820; pc4_dc = 32'h104;
    tick;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    tick;
`ifdef WB_BYPASS_EN
    chk("rf_same_cycle", rs_data_ex, 32'hDEAD_BEEF);
`else
    chk("rf_same_cycle", rs_data_ex, 32'h0);
`endif
    chk("rf_rd_field", {27'b0, rd_ex}, 32'd7);
    wb_en = 1'b0;
    tick;
    chk("rf_after_write", rs_data_ex, 32'hDEAD_BEEF);
    chk("rf_rt_r6", rt_data_ex, 32'h0);
    chk("rf_funct", {26'b0, funct_ex}, 32'h20);
    // r0 write ignored, including any same-cycle bypass
    instruction = 32'h0005_2020;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
    tick; tick;
    chk("rf_r0_read", rs_data_ex, 32'h0);
    chk("rf_rt_r5", rt_data_ex, 32'hDEAD_BEEF);
    wb_en = 1'b0;

    // Load-use stall
    instruction = 32'h012A_5820; pc4_dc = 32'h200;
    tick;
    ex_mem_read = 1'b1; ex_rt = 5'd9;
    instruction = 32'h2008_0005; pc4_dc = 32'h204;
    #1;
    chk("lu_hazard", {31'b0, hazard}, 32'd1);
    tick;
    chk("lu_bubble_valid", {31'b0, valid_ex}, 32'd0);
    chk("lu_bubble_rs", {27'b0, rs_ex}, 32'd0);
    ex_mem_read = 1'b0; ex_rt = 5'd0; #1;
    chk("lu_hazard_drop", {31'b0, hazard}, 32'd0);
    tick;
    chk("lu_issue_valid", {31'b0, valid_ex}, 32'd1);
    chk("lu_issue_rs", {27'b0, rs_ex}, 32'd9);
    chk("lu_issue_rd", {27'b0, rd_ex}, 32'd11);
    chk("lu_issue_pc4", pc4_ex, 32'h200);
    tick;
    chk("lu_next_opcode", {26'b0, opcode_ex}, 32'h08);
    chk("lu_next_pc4", pc4_ex, 32'h204);
    ex_mem_read = 1'b1; ex_rt = 5'd0; #1;
    chk("lu_rt0_nohaz", {31'b0, hazard}, 32'd0);
    ex_mem_read = 1'b0;

    // Flush: both stages become bubbles
    instruction = 32'h012A_5820; pc4_dc = 32'h300;
    tick;
    flush = 1'b1;
    tick;
    chk("fl_valid_1", {31'b0, valid_ex}, 32'd0);
    flush = 1'b0;
    tick;
    chk("fl_valid_2", {31'b0, valid_ex}, 32'd0);
    // flush with hazard: flush wins, no hold
    ex_mem_read = 1'b1; ex_rt = 5'd9; flush = 1'b1; #1;
    chk("flh_hazard_on", {31'b0, hazard}, 32'd1);
    tick;
    chk("flh_hazard_off", {31'b0, hazard}, 32'd0);
    chk("flh_valid", {31'b0, valid_ex}, 32'd0);
    flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    tick; tick;
    chk("flh_resume", {31'b0, valid_ex}, 32'd1);

    // Branch target wrap
    instruction = 32'h2008_0001; pc4_dc = 32'hFFFF_FFFC;
    tick; tick;
    chk("wrap_br", br_target_ex, 32'h0000_0000);
    chk("wrap_imm", imm_ex, 32'd1);

    // Reset mid-operation drops stall and clears state
    ex_mem_read = 1'b1; ex_rt = 5'd8; #1;
    chk("mr_hazard_pre", {31'b0, hazard}, 32'd1);
    rst = 1'b1; #1;
    chk("mr_hazard_rst", {31'b0, hazard}, 32'd0);
    tick;
    chk("mr_valid", {31'b0, valid_ex}, 32'd0);
    chk("mr_pc4", pc4_ex, 32'd0);
    rst = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    instruction = 32'h00A6_3820; pc4_dc = 32'd8;
    tick; tick;
    chk("mr_rf_cleared", rs_data_ex, 32'h0);
    chk("mr_valid_after", {31'b0, valid_ex}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
